decoder_scan_sequencer: RTL
===========================

Name: decoder_scan_sequencer

Overview:
- Upstream driver for the 4-to-16 decoder.
- Generates the 4-bit select code (a = MSB … d = LSB) and the active-high enable. Steps through all 16 codes with a programmable dwell per code and a fixed blanking gap between codes.
- Scanned displays, LED matrices and keypads use it to sweep decoder outputs o0..o15 one at a time.

Parameters:
- DW, 8, width of dwell input and dwell counter.
- BLANK, 2, enable-low cycles between consecutive codes (0 = no gap, 0..255).

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a scan; sampled only in IDLE.
- stop  in  1  abort the scan; sampled in every state.
- mode  in  2  00 = continuous up, 01 = continuous down, 10 = single-shot up, 11 = single-shot down; latched at start.
- dwell  in  DW  enable-high cycles per code; latched at start; value 0 treated as 1.
- a  out  1  select bit 3 (MSB) to decoder.
- b  out  1  select bit 2.
- c  out  1  select bit 1.
- d  out  1  select bit 0 (LSB).
- enable  out  1  decoder enable; high only in ACTIVE.
- busy  out  1  high in ACTIVE and BLANK.
- step_done  out  1  one-cycle pulse on the last ACTIVE cycle of each code.
- wrap  out  1  one-cycle pulse when the code advances 15→0 (up) or 0→15 (down), continuous modes only.
- done  out  1  one-cycle pulse on return to IDLE after a completed single-shot scan.

Behaviour:
- Reset is asynchronous and active-low: rst_n is one clock domain input; the block is fully registered on clk. On rst_n=0, regardless of clock: state=IDLE, code=0, a=b=c=d=0, enable=0, busy=0, step_done=0, wrap=0, done=0, dwell/blank counters=0. Reset mid-scan aborts immediately with no done pulse.
- States: IDLE, ACTIVE, BLANK.
- IDLE:
  - outputs are enable=0, busy=0, and code holds its last value.
  - start=1 and stop=0: latch mode and dwell (0→1) and load code (0 for up modes, 15 for down modes). Enter ACTIVE next cycle. enable rises the cycle after start is sampled (latency 1).
- ACTIVE:
  - enable=1 and the dwell counter counts from 1 up to the latched dwell. The code is stable for exactly dwell cycles.
  - step_done=1 on the final ACTIVE cycle.
  - Then enter BLANK if BLANK>0, otherwise advance directly.
- BLANK: enable=0 and the code holds for exactly BLANK cycles.
- Advance: code ±1 mod 16, entering ACTIVE.
  - Continuous modes: wrap pulses in the same cycle the code register takes the wrapped value.
  - Single-shot modes: the last code (15 up, 0 down) does not advance. After its dwell (and blank) the block returns to IDLE, pulses done for one cycle, and holds the code.
- stop=1 in any state: next cycle state=IDLE, enable=0, busy=0, no done pulse. The code holds.
- start and stop together: stop wins, the block stays or becomes IDLE.
- start while busy is ignored. mode and dwell changes while busy are ignored until the next start.
- The outputs a,b,c,d, enable, busy and the pulses are all registered, with no combinational paths from inputs to outputs.
- Period per code = dwell + BLANK cycles. A full sweep takes 16 × (dwell + BLANK) cycles.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-ACTIVE at code 7 → all outputs 0 immediately, state IDLE, no done.
- Single-shot up, dwell=3, BLANK=2: start pulse.
  - Codes 0..15 each with enable high for 3 cycles then low for 2.
  - 16 step_done pulses, done once after code 15, total 80 cycles, then busy=0.
- Continuous down, dwell=1: codes 15,14,…,0,15.
  - wrap pulses exactly once at the 0→15 transition; enable is never high for two codes without a BLANK gap.
- dwell=0 treated as 1: single-shot up completes in 16 × (1+2) = 48 busy cycles.
- Stop/start conflicts:
  - stop asserted at code 5 during ACTIVE → next cycle enable=0, busy=0, code stays 5, no done.
  - start+stop asserted together in IDLE → remains IDLE.
- Ignore while busy: start re-pulsed and mode/dwell changed mid-scan → no restart; the original timing and direction hold until completion.

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
// Purpose : sweeps a 4-to-16 decoder select code (a=MSB..d=LSB) with per-code dwell and blanking gap.
// Latency : enable rises one cycle after start is sampled in IDLE; every output is a flop.
// Backpr. : none; start is only honoured in IDLE, stop aborts from any state on the next edge.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, stop       scan begin (IDLE only) / abort (any state; wins over start)
//   mode[1:0]         bit1 = single-shot, bit0 = count down; latched at start
//   dwell[DW-1:0]     enable-high cycles per code, 0 behaves as 1; latched at start
//   a, b, c, d        select code to the decoder
//   enable, busy      decoder enable (ACTIVE only) / scan in progress (ACTIVE or BLANK)
//   step_done         pulse on the last ACTIVE cycle of each code
//   wrap              pulse when the code wraps, continuous modes only
//   done              pulse on return to IDLE after a finished single-shot scan
module decoder_scan_sequencer #(
  parameter int DW    = 8,
  parameter int BLANK = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] dwell,
  output logic          a,
  output logic          b,
  output logic          c,
  output logic          d,
  output logic          enable,
  output logic          busy,
  output logic          step_done,
  output logic          wrap,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

  localparam logic [7:0]    BLANK_LEN = 8'(BLANK);
  localparam logic [DW-1:0] DW_ONE    = DW'(1);

  state_t        state, state_nxt;
  logic [3:0]    code, code_nxt;
  logic [1:0]    mode_q, mode_nxt;
  logic [DW-1:0] dwell_q, dwell_nxt;
  logic [DW-1:0] dwell_cnt, dwell_cnt_nxt;
  logic [7:0]    blank_cnt, blank_cnt_nxt;

  logic          enable_nxt;
  logic          busy_nxt;
  logic          step_done_nxt;
  logic          wrap_nxt;
  logic          done_nxt;

  logic          advance;
  logic          single_shot;
  logic          count_down;
  logic          at_last;
  logic [3:0]    code_step;

  // Direction and end-of-sweep come from the latched mode, so mode changes
  // while busy cannot disturb a scan in flight.
  assign single_shot = mode_q[1];
  assign count_down  = mode_q[0];
  assign at_last     = (code == (count_down ? 4'd0 : 4'd15));
  assign code_step   = count_down ? (code - 4'd1) : (code + 4'd1);

  always_comb begin
    state_nxt     = state;
    code_nxt      = code;
    mode_nxt      = mode_q;
    dwell_nxt     = dwell_q;
    dwell_cnt_nxt = dwell_cnt;
    blank_cnt_nxt = blank_cnt;
    wrap_nxt      = 1'b0;
    done_nxt      = 1'b0;
    advance       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          mode_nxt      = mode;
          dwell_nxt     = (dwell == '0) ? DW_ONE : dwell;
          code_nxt      = mode[0] ? 4'd15 : 4'd0;
          dwell_cnt_nxt = DW_ONE;
          state_nxt     = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (dwell_cnt == dwell_q) begin
          if (BLANK_LEN != 8'd0) begin
            state_nxt     = ST_BLANK;
            blank_cnt_nxt = 8'd1;
          end else begin
            advance = 1'b1;
          end
        end else begin
          dwell_cnt_nxt = dwell_cnt + DW_ONE;
        end
      end

      ST_BLANK: begin
        if (blank_cnt == BLANK_LEN) begin
          advance = 1'b1;
        end else begin
          blank_cnt_nxt = blank_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // End of a code period: a single-shot scan finishes on its last code
    // (code is held), otherwise step and flag the wrap in the same edge the
    // code register takes the wrapped value.
    if (advance) begin
      if (single_shot && at_last) begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt     = ST_ACTIVE;
        code_nxt      = code_step;
        dwell_cnt_nxt = DW_ONE;
        wrap_nxt      = !single_shot && at_last;
      end
    end

    // Abort overrides everything above: freeze code and latched settings,
    // drop to IDLE and suppress any pulse that would have fired.
    if (stop) begin
      state_nxt     = ST_IDLE;
      code_nxt      = code;
      mode_nxt      = mode_q;
      dwell_nxt     = dwell_q;
      dwell_cnt_nxt = dwell_cnt;
      blank_cnt_nxt = blank_cnt;
      wrap_nxt      = 1'b0;
      done_nxt      = 1'b0;
    end

    // Outputs are registered from next-state values so they line up with
    // the state they describe.
    enable_nxt    = (state_nxt == ST_ACTIVE);
    busy_nxt      = (state_nxt != ST_IDLE);
    step_done_nxt = (state_nxt == ST_ACTIVE) && (dwell_cnt_nxt == dwell_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      code      <= 4'd0;
      mode_q    <= 2'd0;
      dwell_q   <= '0;
      dwell_cnt <= '0;
      blank_cnt <= 8'd0;
      enable    <= 1'b0;
      busy      <= 1'b0;
      step_done <= 1'b0;
      wrap      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      code      <= code_nxt;
      mode_q    <= mode_nxt;
      dwell_q   <= dwell_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      blank_cnt <= blank_cnt_nxt;
      enable    <= enable_nxt;
      busy      <= busy_nxt;
      step_done <= step_done_nxt;
      wrap      <= wrap_nxt;
      done      <= done_nxt;
    end
  end

  assign a = code[3];
  assign b = code[2];
  assign c = code[1];
  assign d = code[0];

endmodule
